// File: rtl/mem_bus_pkg.sv
// Shared types, widths and command legality check for the native-bus initiator.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_init_state_t;

    // A command is rejected without touching the bus if it is misaligned
    // or is a write that would enable no bytes.
    function automatic logic mem_cmd_illegal(
        input logic                  wr,
        input logic [MEM_ADDR_W-1:0] addr,
        input logic [MEM_STRB_W-1:0] strb
    );
        return (addr[1:0] != 2'b00) || (wr && (strb == '0));
    endfunction

endpackage

// File: rtl/mem_bus_initiator.sv
// Command-port to PicoRV32 native memory bus master: IDLE -> REQ -> RSP -> IDLE.
// Optional REQ timeout enabled by defining MEM_BUS_INITIATOR_TIMEOUT_EN.
module mem_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [MEM_ADDR_W-1:0] cmd_addr,
    input  logic [MEM_DATA_W-1:0] cmd_wdata,
    input  logic [MEM_STRB_W-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_valid,
    output logic                  mem_instr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic [MEM_STRB_W-1:0] mem_wstrb,
    input  logic                  mem_ready,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    output logic                  busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mem_init_state_t       state_q, state_d;
    logic                  wr_q, wr_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MEM_STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [MEM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timeout_hit;

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    // Counter is zero outside REQ, so it is already clear on entry to REQ.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == REQ && !mem_ready) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // Fires on the REQ cycle that would make the wait count reach the limit;
    // a simultaneous mem_ready wins.
    assign timeout_hit = (state_q == REQ) && !mem_ready &&
                         (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    wr_d = cmd_write;
                    if (mem_cmd_illegal(cmd_write, cmd_addr, cmd_wstrb)) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = REQ;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = cmd_addr;
                        mem_wdata_d = cmd_wdata;
                        mem_wstrb_d = cmd_write ? cmd_wstrb : '0;
                    end
                end
            end

            REQ: begin
                if (mem_ready || timeout_hit) begin
                    state_d     = RSP;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !mem_ready;
                    rsp_rdata_d = (mem_ready && !wr_q) ? mem_rdata : '0;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                mem_wstrb_d = '0;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Asynchronous clear so that a reset mid-REQ drops mem_valid immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_instr = 1'b0;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed and randomized checks of mem_bus_initiator against a word-memory
// reference model and a wait-state memory responder.
module tb_mem_bus_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory responder: ready follows valid combinationally after wait_target stalls.
    logic [31:0] resp_mem [0:63];
    int          wait_target = 0;
    int          wcnt = 0;
    logic        tie_low = 1'b0;
    int          mv_cycles = 0;

    assign mem_ready = mem_valid && !tie_low && (wcnt >= wait_target);
    assign mem_rdata = resp_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_valid === 1'b1) mv_cycles <= mv_cycles + 1;
        if (mem_valid && !mem_ready) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (mem_valid && mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) resp_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: word-addressed memory, unwritten words read as 0.
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = w;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE, check bus and response behaviour cycle by cycle.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input int hold,
                          output logic [31:0] got_rdata, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          edges;
        int          n;
        int          mv0;

        exp_err   = (addr[1:0] != 2'b00) || (wr && strb == 4'h0);
        exp_rdata = (exp_err || wr) ? 32'h0 : ref_read(addr);
        if (!exp_err && wr) ref_write(addr, wdata, strb);

        chk("cmd_ready_idle", cmd_ready, 1);
        wait_target = waits;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        mv0 = mv_cycles;
        @(posedge clk); edges = 1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;

        if (!exp_err) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 200) begin
                chk("req_mem_valid", mem_valid, 1);
                chk("req_mem_addr", mem_addr, addr);
                chk("req_mem_wstrb", mem_wstrb, wr ? strb : 4'h0);
                if (wr) chk("req_mem_wdata", mem_wdata, wdata);
                chk("req_cmd_ready", cmd_ready, 0);
                @(posedge clk); edges++;
                @(negedge clk); n++;
            end
            chk("req_cycles", n, waits + 1);
        end

        chk("rsp_mem_valid", mem_valid, 0);
        chk("rsp_mem_addr_idle", mem_addr, 0);
        chk("rsp_mem_wstrb_idle", mem_wstrb, 0);
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_cmd_ready", cmd_ready, 0);
            chk("rsp_busy", busy, 1);
            if (h == hold) rsp_ready = 1'b1;
            @(posedge clk); edges++;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_busy", busy, 0);
        chk("cmd_cycles", edges, 1 + (exp_err ? 0 : waits + 1) + hold + 1);
        chk("mem_valid_cycles", mv_cycles - mv0, exp_err ? 0 : waits + 1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        r_wr;
        logic [31:0] r_addr;
        logic [3:0]  r_strb;
        int          n;

        for (int i = 0; i < 64; i++) resp_mem[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_mem_instr", mem_instr, 0);

        // Write then read
        do_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, rd, er);
        do_cmd(1'b0, 32'h100, 32'h0, 4'h0, 0, 0, rd, er);
        chk("wr_rd_data", rd, 32'hDEADBEEF);
        chk("wr_rd_err", er, 0);

        // Byte write
        do_cmd(1'b1, 32'h104, 32'h11223344, 4'hF, 0, 0, rd, er);
        do_cmd(1'b1, 32'h104, 32'h00AA0000, 4'b0100, 0, 0, rd, er);
        do_cmd(1'b0, 32'h104, 32'h0, 4'h0, 0, 0, rd, er);
        chk("byte_wr_data", rd, 32'h11AA3344);

        // Misaligned read and zero-strobe write
        do_cmd(1'b0, 32'h102, 32'h0, 4'h0, 0, 0, rd, er);
        chk("misaligned_err", er, 1);
        chk("misaligned_rdata", rd, 0);
        do_cmd(1'b1, 32'h108, 32'h12345678, 4'h0, 0, 1, rd, er);
        chk("zero_strb_err", er, 1);

        // Wait states and back-pressure
        do_cmd(1'b1, 32'h10C, 32'hCAFEF00D, 4'hF, 5, 3, rd, er);
        do_cmd(1'b0, 32'h10C, 32'h0, 4'h0, 5, 3, rd, er);
        chk("wait_rd_data", rd, 32'hCAFEF00D);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
            r_strb = 4'($urandom_range(0, 15));
            do_cmd(r_wr, r_addr, $urandom, r_strb, $urandom_range(0, 3), $urandom_range(0, 2), rd, er);
        end

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
        // Timeout with mem_ready tied low
        tie_low = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            chk("to_mem_valid", mem_valid, 1);
            @(posedge clk);
            @(negedge clk); n++;
        end
        chk("to_req_cycles", n, 8);
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_mem_valid_low", mem_valid, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        tie_low = 1'b0;
        chk("to_cmd_ready", cmd_ready, 1);
`endif

        // Reset in the middle of REQ
        wait_target = 20;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h104;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_req_mem_valid", mem_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_mem_valid", mem_valid, 0);
        chk("async_rst_cmd_ready", cmd_ready, 1);
        chk("async_rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_target = 0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_mem_valid", mem_valid, 0);

        // Bus still usable after reset
        do_cmd(1'b0, 32'h104, 32'h0, 4'h0, 1, 0, rd, er);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
